// File: rtl/branch_predictor_if.sv
// Fetch-prediction and EX-resolution signals of the branch predictor.
// The pipeline side is the master and the predictor is the slave.
interface branch_predictor_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc_f;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_pred_taken;
  logic [XLEN-1:0] upd_pred_target;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     br_count;
  logic [31:0]     mispred_count;

  modport master (
    output pc_f, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc, br_count, mispred_count
  );

  modport slave (
    input  pc_f, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc, br_count, mispred_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: 2-bit saturating counters with tag and target,
// same-cycle prediction for IF, mispredict/redirect for EX, saturating perf counters.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int XLEN    = 32
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bus
);
  localparam int TAG_W = XLEN - IDX_W - 2;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [XLEN-1:0]  addr_t;

  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  tag_t               tag_q    [ENTRIES];
  tag_t               tag_d    [ENTRIES];
  addr_t              target_q [ENTRIES];
  addr_t              target_d [ENTRIES];
  logic [31:0]        br_count_q, br_count_d;
  logic [31:0]        mispred_count_q, mispred_count_d;

  idx_t  idx_f, idx_u;
  tag_t  tag_f, tag_u;
  logic  hit_u;
  logic  mispredict_raw;

  // Word-alignment bits of the PCs carry no index or tag information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pc_f[1:0], bus.upd_pc[1:0]};

  assign idx_f = bus.pc_f[IDX_W+1:2];
  assign tag_f = bus.pc_f[XLEN-1:IDX_W+2];
  assign idx_u = bus.upd_pc[IDX_W+1:2];
  assign tag_u = bus.upd_pc[XLEN-1:IDX_W+2];
  assign hit_u = valid_q[idx_u] && (tag_q[idx_u] == tag_u);

  // Prediction reads the registered table, so a same-cycle update is not seen.
  assign bus.pred_taken  = valid_q[idx_f] && (tag_q[idx_f] == tag_f) && ctr_q[idx_f][1];
  assign bus.pred_target = target_q[idx_f];

  assign mispredict_raw  = (bus.upd_pred_taken != bus.upd_taken) ||
                           (bus.upd_taken && bus.upd_pred_taken &&
                            (bus.upd_pred_target != bus.upd_target));
  assign bus.mispredict  = bus.upd_valid && mispredict_raw;
  assign bus.redirect_pc = !bus.upd_valid ? '0 :
                           bus.upd_taken  ? bus.upd_target : bus.upd_pc + addr_t'(4);

  assign bus.br_count      = br_count_q;
  assign bus.mispred_count = mispred_count_q;

  always_comb begin
    // NOTE: every next-state variable takes its hold value first, so no path infers a latch.
    valid_d         = valid_q;
    ctr_d           = ctr_q;
    tag_d           = tag_q;
    target_d        = target_q;
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;

    if (bus.upd_valid) begin
      if (hit_u) begin
        if (bus.upd_taken) begin
          if (ctr_q[idx_u] != 2'b11) ctr_d[idx_u] = ctr_q[idx_u] + 2'd1;
          target_d[idx_u] = bus.upd_target;
        end else if (ctr_q[idx_u] != 2'b00) begin
          ctr_d[idx_u] = ctr_q[idx_u] - 2'd1;
        end
      end else if (bus.upd_taken) begin
        valid_d[idx_u]  = 1'b1;
        tag_d[idx_u]    = tag_u;
        target_d[idx_u] = bus.upd_target;
        ctr_d[idx_u]    = CTR_ALLOC;
      end

      if (br_count_q != '1) br_count_d = br_count_q + 32'd1;
      if (mispredict_raw && (mispred_count_q != '1)) mispred_count_d = mispred_count_q + 32'd1;
    end
  end

  // NOTE: the table lives in flops and is fully cleared by reset; an empty table must
  // never predict taken, and reset takes priority over any update in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst) begin
      valid_q         <= '0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i]    <= CTR_RESET;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else begin
      valid_q         <= valid_d;
      ctr_q           <= ctr_d;
      tag_q           <= tag_d;
      target_q        <= target_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table from the test plan,
// reset-with-update corner case, then randomized traffic against a behavioural model.
module tb_branch_predictor;
  localparam int XLEN    = 32;
  localparam int IDX_W   = 4;
  localparam int ENTRIES = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_if #(.XLEN(XLEN)) bus ();

  branch_predictor #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc_f, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic upt,
                       input logic [31:0] uptgt);
    bus.pc_f            = pc_f;
    bus.upd_valid       = uv;
    bus.upd_pc          = upc;
    bus.upd_taken       = ut;
    bus.upd_target      = utgt;
    bus.upd_pred_taken  = upt;
    bus.upd_pred_target = uptgt;
  endtask

  typedef struct {
    logic [31:0] pc_f;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        upt;
    logic [31:0] uptgt;
    logic        ept;
    logic [31:0] eptgt;
    logic        emis;
    logic [31:0] eredir;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: per table slot, who owns it and how strongly it leans taken.
  bit          m_valid [ENTRIES];
  logic [31:0] m_owner [ENTRIES];
  int          m_str   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  longint      m_br, m_mis;
  localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] owner(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_owner[i] = '0;
      m_str[i]   = 1;
      m_tgt[i]   = '0;
    end
    m_br  = 0;
    m_mis = 0;
  endtask

  initial begin
    logic [31:0] pcs [4];
    logic [31:0] pc_f, upc, utgt, uptgt, eredir, etgt;
    logic        uv, ut, upt, ept, emis, r;
    int          s;

    pcs = '{32'h100, 32'h104, 32'h144, 32'hFFFF_FFFC};

    // pc_f, uv, upc, ut, utgt, upt, uptgt | exp pred_taken, pred_target, mispredict, redirect
    vecs.push_back('{32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0});
    vecs.push_back('{32'h100, 1, 32'h100, 1, 32'h80,  0, 32'h0,  0, 32'h0,   1, 32'h80});
    vecs.push_back('{32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,  1, 32'h80,  0, 32'h0});
    vecs.push_back('{32'h100, 1, 32'h100, 0, 32'h80,  1, 32'h80, 1, 32'h80,  1, 32'h104});
    vecs.push_back('{32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0});
    vecs.push_back('{32'h100, 1, 32'h100, 1, 32'h80,  0, 32'h0,  0, 32'h0,   1, 32'h80});
    vecs.push_back('{32'h100, 1, 32'h100, 1, 32'h80,  1, 32'h80, 1, 32'h80,  0, 32'h80});
    vecs.push_back('{32'h100, 1, 32'h100, 1, 32'h80,  1, 32'h80, 1, 32'h80,  0, 32'h80});
    vecs.push_back('{32'h100, 1, 32'h100, 1, 32'h80,  1, 32'h80, 1, 32'h80,  0, 32'h80});
    vecs.push_back('{32'h100, 1, 32'h100, 1, 32'h80,  1, 32'h80, 1, 32'h80,  0, 32'h80});
    vecs.push_back('{32'h100, 1, 32'h100, 0, 32'h80,  1, 32'h80, 1, 32'h80,  1, 32'h104});
    vecs.push_back('{32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,  1, 32'h80,  0, 32'h0});
    vecs.push_back('{32'h100, 1, 32'h100, 1, 32'h90,  1, 32'h80, 1, 32'h80,  1, 32'h90});
    vecs.push_back('{32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,  1, 32'h90,  0, 32'h0});
    vecs.push_back('{32'h104, 1, 32'h104, 1, 32'h200, 0, 32'h0,  0, 32'h0,   1, 32'h200});
    vecs.push_back('{32'h144, 0, 32'h0,   0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0});
    vecs.push_back('{32'h104, 0, 32'h0,   0, 32'h0,   0, 32'h0,  1, 32'h200, 0, 32'h0});
    vecs.push_back('{32'h144, 1, 32'h144, 1, 32'h300, 0, 32'h0,  0, 32'h0,   1, 32'h300});
    vecs.push_back('{32'h104, 0, 32'h0,   0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0});
    vecs.push_back('{32'h144, 0, 32'h0,   0, 32'h0,   0, 32'h0,  1, 32'h300, 0, 32'h0});
    vecs.push_back('{32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h40, 1, 32'h40, 0, 32'h0, 1, 32'h0});
    vecs.push_back('{32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0});

    rst = 1'b1;
    drive(32'h100, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    #2;
    check("reset br_count", bus.br_count, 32'd0);
    check("reset mispred_count", bus.mispred_count, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].pc_f, vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utgt,
            vecs[i].upt, vecs[i].uptgt);
      #2;
      check($sformatf("vec%0d pred_taken", i), 32'(bus.pred_taken), 32'(vecs[i].ept));
      if (vecs[i].ept) check($sformatf("vec%0d pred_target", i), bus.pred_target, vecs[i].eptgt);
      check($sformatf("vec%0d mispredict", i), 32'(bus.mispredict), 32'(vecs[i].emis));
      check($sformatf("vec%0d redirect_pc", i), bus.redirect_pc, vecs[i].eredir);
      tick();
    end
    check("vec br_count", bus.br_count, 32'd12);
    check("vec mispred_count", bus.mispred_count, 32'd8);

    // Reset together with an update: the update is discarded.
    rst = 1'b1;
    drive(32'h144, 1, 32'h100, 1, 32'h500, 0, 32'h0);
    tick();
    rst = 1'b0;
    drive(32'h100, 0, 0, 0, 0, 0, 0);
    #2;
    check("rst+upd br_count", bus.br_count, 32'd0);
    check("rst+upd mispred_count", bus.mispred_count, 32'd0);
    check("rst+upd pred 0x100", 32'(bus.pred_taken), 32'd0);
    drive(32'h144, 0, 0, 0, 0, 0, 0);
    #2;
    check("rst+upd pred 0x144", 32'(bus.pred_taken), 32'd0);

    model_clear();
    for (int n = 0; n < 3000; n++) begin
      pc_f  = pcs[$urandom_range(0, 3)] + (32'($urandom_range(0, 3)) << 2);
      upc   = pcs[$urandom_range(0, 3)] + (32'($urandom_range(0, 3)) << 2);
      uv    = ($urandom_range(0, 3) != 0);
      ut    = $urandom_range(0, 1) != 0;
      utgt  = 32'($urandom_range(0, 3)) << 4;
      upt   = $urandom_range(0, 1) != 0;
      uptgt = 32'($urandom_range(0, 3)) << 4;
      r     = ($urandom_range(0, 199) == 0);
      rst   = r;
      drive(pc_f, uv, upc, ut, utgt, upt, uptgt);
      #2;

      s    = slot(pc_f);
      ept  = m_valid[s] && (m_owner[s] == owner(pc_f)) && (m_str[s] >= 2);
      etgt = m_tgt[s];
      emis = uv && ((upt != ut) || (ut && upt && (uptgt != utgt)));
      eredir = !uv ? 32'h0 : (ut ? utgt : upc + 32'd4);

      check("rnd pred_taken", 32'(bus.pred_taken), 32'(ept));
      if (ept) check("rnd pred_target", bus.pred_target, etgt);
      check("rnd mispredict", 32'(bus.mispredict), 32'(emis));
      check("rnd redirect_pc", bus.redirect_pc, eredir);
      check("rnd br_count", bus.br_count, m_br[31:0]);
      check("rnd mispred_count", bus.mispred_count, m_mis[31:0]);

      if (r) begin
        model_clear();
      end else if (uv) begin
        s = slot(upc);
        if (m_valid[s] && m_owner[s] == owner(upc)) begin
          if (ut) begin
            m_str[s] = (m_str[s] + 1 > 3) ? 3 : m_str[s] + 1;
            m_tgt[s] = utgt;
          end else begin
            m_str[s] = (m_str[s] - 1 < 0) ? 0 : m_str[s] - 1;
          end
        end else if (ut) begin
          m_valid[s] = 1'b1;
          m_owner[s] = owner(upc);
          m_tgt[s]   = utgt;
          m_str[s]   = 2;
        end
        m_br = (m_br < CNT_MAX) ? m_br + 1 : m_br;
        if (emis) m_mis = (m_mis < CNT_MAX) ? m_mis + 1 : m_mis;
      end
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
